// File: rtl/ysyx_22050133_ifu_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit.
package ysyx_22050133_ifu_pkg;

  localparam logic [63:0] IFU_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } ifu_state_e;

endpackage

// File: rtl/ysyx_22050133_ifu.sv
// Instruction fetch stage: owns the fetch PC, issues one imem request at a time and
// holds the fetched instruction until decode consumes it; redirects kill in-flight fetches.
module ysyx_22050133_ifu
  import ysyx_22050133_ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = IFU_RESET_PC,
  parameter logic [31:0] NOP_INST = IFU_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  output logic        imem_resp_ready,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_inst
);

  ifu_state_e  state;
  logic [63:0] fetch_pc;
  logic [63:0] fetch_pc_next;
  logic [63:0] req_addr;
  logic        req_valid_q;
  logic        kill;
  logic        req_hs;
  logic        resp_hs;
  logic        capture;

  assign imem_req_valid  = req_valid_q;
  assign imem_req_addr   = req_addr;
  assign imem_resp_ready = (state == S_WAIT) && (!if_valid || !stall);

  assign req_hs  = imem_req_valid && imem_req_ready;
  assign resp_hs = imem_resp_valid && imem_resp_ready;
  assign capture = resp_hs && !kill && !redirect_valid;

  // NOTE: default assignment first so every path drives fetch_pc_next and no latch is inferred.
  always_comb begin
    fetch_pc_next = fetch_pc;
    if (redirect_valid) begin
      fetch_pc_next = {redirect_pc[63:2], 2'b00};
    end else if (capture) begin
      fetch_pc_next = fetch_pc + 64'd4;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      req_addr    <= RESET_PC;
      req_valid_q <= 1'b0;
      kill        <= 1'b0;
      if_valid    <= 1'b0;
      if_pc       <= RESET_PC;
      if_inst     <= NOP_INST;
    end else begin
      fetch_pc <= fetch_pc_next;

      // req_addr is only loaded on entry to REQ, which keeps the port address stable
      // while a request is waiting for ready even if a redirect moves fetch_pc.
      unique case (state)
        S_IDLE: begin
          state       <= S_REQ;
          req_valid_q <= 1'b1;
          req_addr    <= fetch_pc_next;
        end
        S_REQ: begin
          if (req_hs) begin
            state       <= S_WAIT;
            req_valid_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (resp_hs) begin
            state       <= S_REQ;
            req_valid_q <= 1'b1;
            req_addr    <= fetch_pc_next;
          end
        end
        default: begin
          state       <= S_IDLE;
          req_valid_q <= 1'b0;
        end
      endcase

      // A redirect with a transaction still outstanding must drop its response later.
      if (redirect_valid && ((state == S_REQ) || ((state == S_WAIT) && !resp_hs))) begin
        kill <= 1'b1;
      end else if (resp_hs) begin
        kill <= 1'b0;
      end

      if (redirect_valid) begin
        if_valid <= 1'b0;
        if_inst  <= NOP_INST;
      end else if (capture) begin
        if_valid <= 1'b1;
        if_pc    <= fetch_pc;
        if_inst  <= imem_resp_data;
      end else if (if_valid && !stall) begin
        if_valid <= 1'b0;
        if_inst  <= NOP_INST;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_ifu.sv
// Directed bench for the fetch stage with a simple single-outstanding instruction memory model.
module tb_ysyx_22050133_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic        imem_resp_ready;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_inst;

  int checks = 0;
  int errors = 0;

  // Memory model: constant word or low address bits as data, programmable response delay.
  logic        const_mode;
  int          resp_delay;
  logic        pending;
  logic [63:0] pend_addr;
  int          pend_cnt;

  always #5 clk = ~clk;

  ysyx_22050133_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_ready (imem_resp_ready),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst)
  );

  assign imem_resp_valid = pending && (pend_cnt == 0);
  assign imem_resp_data  = const_mode ? 32'h0010_0093 : pend_addr[31:0];

  always @(posedge clk) begin
    if (rst) begin
      pending  <= 1'b0;
      pend_cnt <= 0;
    end else begin
      if (imem_resp_valid && imem_resp_ready) begin
        pending <= 1'b0;
      end else if (pending && pend_cnt > 0) begin
        pend_cnt <= pend_cnt - 1;
      end
      if (imem_req_valid && imem_req_ready) begin
        pending   <= 1'b1;
        pend_addr <= imem_req_addr;
        pend_cnt  <= resp_delay;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic cmode, input int delay);
    const_mode     = cmode;
    resp_delay     = delay;
    imem_req_ready = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    rst            = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    // 1: reset values, first fetch latency, sequential pc
    do_reset(1'b1, 0);
    rst = 1'b1;
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_if_pc", if_pc, 64'h8000_0000);
    check("rst_if_inst", if_inst, 32'h0000_0013);
    check("rst_req_valid", imem_req_valid, 1'b0);
    check("rst_resp_ready", imem_resp_ready, 1'b0);
    rst = 1'b0;
    tick();
    check("t1_req_valid", imem_req_valid, 1'b1);
    check("t1_req_addr", imem_req_addr, 64'h8000_0000);
    tick();
    check("t1_resp_ready", imem_resp_ready, 1'b1);
    check("t1_not_valid_yet", if_valid, 1'b0);
    tick();
    check("t1_valid", if_valid, 1'b1);
    check("t1_pc0", if_pc, 64'h8000_0000);
    check("t1_inst0", if_inst, 32'h0010_0093);
    tick();
    check("t1_consumed", if_valid, 1'b0);
    tick();
    check("t1_valid1", if_valid, 1'b1);
    check("t1_pc1", if_pc, 64'h8000_0004);

    // 2: stall holds the output register and blocks the response
    do_reset(1'b0, 0);
    tick();
    tick();
    tick();
    check("t2_pc0", if_pc, 64'h8000_0000);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_valid", if_valid, 1'b1);
      check("t2_hold_pc", if_pc, 64'h8000_0000);
      check("t2_hold_inst", if_inst, 32'h8000_0000);
      check("t2_no_resp_ready", imem_resp_ready, 1'b0);
    end
    check("t2_mem_holding", imem_resp_valid, 1'b1);
    stall = 1'b0;
    tick();
    check("t2_next_valid", if_valid, 1'b1);
    check("t2_next_pc", if_pc, 64'h8000_0004);
    check("t2_next_inst", if_inst, 32'h8000_0004);

    // 3: redirect in WAIT kills the late response
    do_reset(1'b0, 3);
    tick();
    tick();
    check("t3_in_wait", imem_req_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_0103;
    tick();
    redirect_valid = 1'b0;
    check("t3_valid_after_redir", if_valid, 1'b0);
    tick();
    tick();
    check("t3_drain_ready", imem_resp_ready, 1'b1);
    tick();
    check("t3_dropped", if_valid, 1'b0);
    check("t3_req_valid", imem_req_valid, 1'b1);
    check("t3_req_addr", imem_req_addr, 64'h8000_0100);
    resp_delay = 0;
    tick();
    tick();
    check("t3_valid", if_valid, 1'b1);
    check("t3_pc", if_pc, 64'h8000_0100);
    check("t3_inst", if_inst, 32'h8000_0100);

    // 4: redirect with resp handshake, then two redirects during kill
    do_reset(1'b0, 0);
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_0200;
    tick();
    redirect_valid = 1'b0;
    check("t4_valid", if_valid, 1'b0);
    check("t4_req_valid", imem_req_valid, 1'b1);
    check("t4_req_addr", imem_req_addr, 64'h8000_0200);
    resp_delay = 3;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_0300;
    tick();
    redirect_pc = 64'h0000_0000_8000_0400;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    check("t4_kill_dropped", if_valid, 1'b0);
    check("t4_kill_req_valid", imem_req_valid, 1'b1);
    check("t4_kill_req_addr", imem_req_addr, 64'h8000_0400);
    resp_delay = 0;
    tick();
    tick();
    check("t4_valid2", if_valid, 1'b1);
    check("t4_pc2", if_pc, 64'h8000_0400);
    check("t4_inst2", if_inst, 32'h8000_0400);

    // 5: request held by ready=0, redirect must not move the port address
    do_reset(1'b0, 0);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_hold_valid", imem_req_valid, 1'b1);
      check("t5_hold_addr", imem_req_addr, 64'h8000_0000);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_0500;
    tick();
    redirect_valid = 1'b0;
    check("t5_addr_stable", imem_req_addr, 64'h8000_0000);
    check("t5_valid_stable", imem_req_valid, 1'b1);
    imem_req_ready = 1'b1;
    tick();
    check("t5_in_wait", imem_req_valid, 1'b0);
    tick();
    check("t5_dropped", if_valid, 1'b0);
    check("t5_req_addr", imem_req_addr, 64'h8000_0500);
    tick();
    tick();
    check("t5_valid", if_valid, 1'b1);
    check("t5_pc", if_pc, 64'h8000_0500);
    check("t5_inst", if_inst, 32'h8000_0500);

    // 6: redirect from IDLE, pc wrap, reset while in WAIT
    do_reset(1'b0, 0);
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    check("t6_req_valid", imem_req_valid, 1'b1);
    check("t6_req_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    tick();
    check("t6_valid", if_valid, 1'b1);
    check("t6_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("t6_inst", if_inst, 32'hFFFF_FFFC);
    check("t6_wrap_addr", imem_req_addr, 64'h0);
    tick();
    check("t6_wait_ready", imem_resp_ready, 1'b1);
    rst = 1'b1;
    tick();
    check("t6_rst_valid", if_valid, 1'b0);
    check("t6_rst_inst", if_inst, 32'h0000_0013);
    check("t6_rst_pc", if_pc, 64'h8000_0000);
    check("t6_rst_req_valid", imem_req_valid, 1'b0);
    check("t6_rst_resp_ready", imem_resp_ready, 1'b0);
    rst = 1'b0;
    tick();
    check("t6_restart_valid", imem_req_valid, 1'b1);
    check("t6_restart_addr", imem_req_addr, 64'h8000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
